// File: rtl/hdmi_pkg.sv
// Shared definitions for the frame-buffer stream writer.
//   REG_*       : word offsets of the slave register file
//   state_t     : writer sequencing states
//   pack_pixel  : 24-bit RGB -> 32-bit SDRAM word in the scan-out layout
package hdmi_pkg;

  localparam logic [11:0] REG_BASE   = 12'd0;
  localparam logic [11:0] REG_CTRL   = 12'd1;
  localparam logic [11:0] REG_STATUS = 12'd2;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    BURST,
    NEXT,
    DONE
  } state_t;

  function automatic logic [31:0] pack_pixel(input logic [23:0] rgb);
    return {8'h00, rgb};
  endfunction

endpackage

// File: rtl/fb_fifo.sv
// Synchronous show-ahead FIFO.
//   clk, reset (async, active-low)
//   push/wr_data : write side, ignored when full
//   pop          : advance head, ignored when empty
//   head         : current oldest word, valid whenever !empty
//   count/full/empty : occupancy
// Depth must be a power of two so the pointers wrap naturally.
module fb_fifo #(
  parameter int width = 24,
  parameter int depth = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [width-1:0]         wr_data,
  input  logic                     pop,
  output logic [width-1:0]         head,
  output logic [$clog2(depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage has no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == cw'(depth));
  assign empty = (count == '0);

endmodule

// File: rtl/fb_stream_writer.sv
// Frame-buffer stream writer: buffers a 24-bit RGB pixel stream and writes
// each frame to SDRAM as Avalon-MM write bursts, one {8'h00,R,G,B} word per
// pixel, rows contiguous from a programmable base.
//   clk, reset (async, active-low)
//   s_*          : register slave (BASE, CTRL, STATUS), read data one cycle late
//   px_*         : pixel stream in, valid/ready handshake, px_sof marks pixel 0
//   m_*          : Avalon-MM burst write master
//   frame_done   : one-cycle pulse once the last beat of a frame is accepted
//
// state | meaning
// IDLE  | waiting for an enabled start-of-frame pixel; non-sof pixels dropped
// FILL  | collecting pixels until a full burst is buffered
// BURST | streaming one burst to SDRAM, one beat per non-stalled cycle
// NEXT  | advance address, count down words left in the frame
// DONE  | pulse frame_done, bump frame count
module fb_stream_writer
  import hdmi_pkg::*;
#(
  parameter int horz_pix   = 1024,
  parameter int vert_pix   = 600,
  parameter int burst_len  = 256,
  parameter int fifo_depth = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_write,
  input  logic        s_read,
  input  logic        s_chipselect,
  input  logic [11:0] s_address,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic [23:0] px_data,
  input  logic        px_sof,
  output logic        m_write,
  output logic [29:0] m_address,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  output logic [10:0] m_burstcount,
  input  logic        m_waitrequest,
  output logic        frame_done
);

  localparam int          cw          = $clog2(fifo_depth) + 1;
  localparam logic [31:0] frame_words = 32'(horz_pix * vert_pix);

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   base_reg;
  logic          enable;
  logic          overflow;
  logic          sync_err;
  logic [15:0]   frame_cnt;
  logic [29:0]   addr;
  logic [31:0]   words_left;
  logic [10:0]   beats_left;

  logic          px_accept;
  logic          sof_start;
  logic          beat;
  logic          fifo_push;
  logic          fifo_pop;
  logic [23:0]   fifo_head;
  logic [cw-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          reg_wr;

  fb_fifo #(
    .width (24),
    .depth (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data (px_data),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // IDLE always accepts so pre-frame junk drains without stalling upstream.
  assign px_ready  = (state == IDLE) || !fifo_full;
  assign px_accept = px_valid && px_ready;
  assign sof_start = (state == IDLE) && px_accept && px_sof && enable;
  assign fifo_push = sof_start || ((state != IDLE) && px_accept);
  assign beat      = (state == BURST) && !m_waitrequest;
  assign fifo_pop  = beat && !fifo_empty;
  assign reg_wr    = s_chipselect && s_write;

  assign m_address    = addr;
  assign m_burstcount = 11'(burst_len);
  assign m_byteenable = 4'b1111;
  assign m_writedata  = m_write ? pack_pixel(fifo_head) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    m_write    = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (sof_start) state_nxt = FILL;
      FILL:  if (fifo_count >= cw'(burst_len)) state_nxt = BURST;
      BURST: begin
        m_write = 1'b1;
        if (beat && beats_left == 11'd1) state_nxt = NEXT;
      end
      // Frame end is decided by word count, never by a later sof.
      NEXT:  state_nxt = (words_left == 32'(burst_len)) ? DONE : FILL;
      DONE:  begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr       <= '0;
      words_left <= '0;
      beats_left <= '0;
      frame_cnt  <= '0;
    end else begin
      // BASE is sampled only here, so mid-frame writes apply to the next frame.
      if (sof_start) begin
        addr       <= base_reg[31:2];
        words_left <= frame_words;
      end
      if (state == FILL && state_nxt == BURST) beats_left <= 11'(burst_len);
      else if (beat)                           beats_left <= beats_left - 11'd1;
      if (state == NEXT) begin
        addr       <= addr + 30'(burst_len);
        words_left <= words_left - 32'(burst_len);
      end
      if (state == DONE) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_reg   <= '0;
      enable     <= 1'b0;
      overflow   <= 1'b0;
      sync_err   <= 1'b0;
      s_readdata <= '0;
    end else begin
      if (reg_wr) begin
        case (s_address)
          REG_BASE:   base_reg <= s_writedata;
          REG_CTRL:   enable   <= s_writedata[0];
          REG_STATUS: begin
            overflow <= 1'b0;
            sync_err <= 1'b0;
          end
          default: ;
        endcase
      end
      // A new event in the same cycle as a clear is kept.
      if (state != IDLE && px_valid && fifo_full) overflow <= 1'b1;
      if (state != IDLE && px_accept && px_sof)   sync_err <= 1'b1;
      if (s_chipselect && s_read) begin
        case (s_address)
          REG_BASE:   s_readdata <= base_reg;
          REG_CTRL:   s_readdata <= {31'd0, enable};
          REG_STATUS: s_readdata <= {frame_cnt, 13'd0, sync_err, overflow, (state != IDLE)};
          default:    s_readdata <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fb_stream_writer.sv
module tb_fb_stream_writer;

  localparam int HP = 8;
  localparam int VP = 2;
  localparam int BL = 4;
  localparam int FD = 8;
  localparam int FW = HP * VP;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_write = 1'b0;
  logic        s_read = 1'b0;
  logic        s_chipselect = 1'b0;
  logic [11:0] s_address = '0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic        px_valid = 1'b0;
  logic        px_ready;
  logic [23:0] px_data = '0;
  logic        px_sof = 1'b0;
  logic        m_write;
  logic [29:0] m_address;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic [10:0] m_burstcount;
  logic        m_waitrequest = 1'b0;
  logic        frame_done;

  fb_stream_writer #(
    .horz_pix   (HP),
    .vert_pix   (VP),
    .burst_len  (BL),
    .fifo_depth (FD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_write       (s_write),
    .s_read        (s_read),
    .s_chipselect  (s_chipselect),
    .s_address     (s_address),
    .s_writedata   (s_writedata),
    .s_readdata    (s_readdata),
    .px_valid      (px_valid),
    .px_ready      (px_ready),
    .px_data       (px_data),
    .px_sof        (px_sof),
    .m_write       (m_write),
    .m_address     (m_address),
    .m_writedata   (m_writedata),
    .m_byteenable  (m_byteenable),
    .m_burstcount  (m_burstcount),
    .m_waitrequest (m_waitrequest),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       log_q[$];
  int          acc_q[$];
  int          rise_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_done = 0;
  int          n_acc = 0;
  int          n_stall = 0;
  int          cyc = 0;
  logic [29:0] model_base_w = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected SDRAM image of one frame: word i holds pixel i, and every beat of
  // a burst carries the burst's start address.
  task automatic model_frame(input int first);
    for (int i = 0; i < FW; i++) begin
      beat_t b;
      b.addr = model_base_w + 30'((i / BL) * BL);
      b.data = {8'h00, 24'(first + i)};
      exp_q.push_back(b);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : compare
    logic        prev_stall;
    logic        prev_mw;
    logic [29:0] prev_addr;
    logic [31:0] prev_data;
    logic [10:0] prev_bc;
    prev_stall = 1'b0;
    prev_mw    = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    prev_bc    = '0;
    forever begin
      @(negedge clk);
      if (reset && m_write) begin
        if (!prev_mw) rise_q.push_back(cyc);
        if (prev_stall) begin
          chk("stall_addr", 64'(m_address), 64'(prev_addr));
          chk("stall_data", 64'(m_writedata), 64'(prev_data));
          chk("stall_burstcount", 64'(m_burstcount), 64'(prev_bc));
        end
        if (m_waitrequest) n_stall++;
        else begin
          if (exp_q.size() == 0) chk("beat_expected", 64'(exp_q.size()), 64'd1);
          else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("beat_addr", 64'(m_address), 64'(e.addr));
            chk("beat_data", 64'(m_writedata), 64'(e.data));
            chk("beat_burstcount", 64'(m_burstcount), 64'(BL));
            chk("beat_byteenable", 64'(m_byteenable), 64'hF);
          end
          log_q.push_back('{m_address, m_writedata});
        end
        prev_stall = m_waitrequest;
        prev_addr  = m_address;
        prev_data  = m_writedata;
        prev_bc    = m_burstcount;
      end else prev_stall = 1'b0;
      prev_mw = reset && m_write;
      if (reset && frame_done) n_done++;
    end
  end

  task automatic reg_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    s_chipselect = 1'b1;
    s_write      = 1'b1;
    s_address    = a;
    s_writedata  = d;
    @(posedge clk);
    #1;
    s_write      = 1'b0;
    s_chipselect = 1'b0;
  endtask

  task automatic reg_read(input logic [11:0] a, output logic [31:0] d);
    @(negedge clk);
    s_chipselect = 1'b1;
    s_read       = 1'b1;
    s_address    = a;
    @(posedge clk);
    #1;
    s_read       = 1'b0;
    s_chipselect = 1'b0;
    d = s_readdata;
  endtask

  // Upstream that honours px_ready: valid is raised only when ready is seen.
  task automatic drive_px(input logic [23:0] d, input logic sof, output bit ok);
    int t;
    t  = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!px_ready) begin
      t++;
      if (t > 400) begin
        ok = 1'b0;
        return;
      end
      @(negedge clk);
    end
    px_valid = 1'b1;
    px_data  = d;
    px_sof   = sof;
    acc_q.push_back(cyc);
    @(posedge clk);
    #1;
    px_valid = 1'b0;
    px_sof   = 1'b0;
    n_acc++;
  endtask

  task automatic send_pixels(input int first, input int n, input bit with_sof);
    bit ok;
    for (int i = 0; i < n; i++) begin
      drive_px(24'(first + i), with_sof && (i == 0), ok);
      if (!ok) begin
        chk("px_ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (n_done < target && t < 600) begin
      @(posedge clk);
      t++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("frame_done_count", 64'(n_done), 64'(target));
  endtask

  task automatic wait_log(input int target);
    int t;
    t = 0;
    while (log_q.size() < target && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (log_q.size() < target) chk("beat_timeout", 64'(log_q.size()), 64'(target));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int s;
    int a0;
    int st0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_write", 64'(m_write), 64'd0);
    chk("rst_m_address", 64'(m_address), 64'd0);
    chk("rst_m_burstcount", 64'(m_burstcount), 64'(BL));
    chk("rst_m_byteenable", 64'(m_byteenable), 64'hF);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_s_readdata", 64'(s_readdata), 64'd0);
    chk("rst_px_ready", 64'(px_ready), 64'd1);
    reset = 1'b1;
    reg_read(12'd2, rd);
    chk("rst_status", 64'(rd), 64'd0);

    // Basic frame with first-write latency
    reg_write(12'd0, 32'h0000_1000);
    reg_write(12'd1, 32'h1);
    model_base_w = 30'h400;
    s = log_q.size();
    acc_q.delete();
    rise_q.delete();
    model_frame(32'h1);
    send_pixels(32'h1, FW, 1'b1);
    wait_done(1);
    chk("basic_beats", 64'(log_q.size() - s), 64'(FW));
    chk("basic_first_addr", 64'(log_q[s].addr), 64'h400);
    chk("basic_first_data", 64'(log_q[s].data), 64'h0000_0001);
    chk("basic_last_addr", 64'(log_q[s+15].addr), 64'h40C);
    chk("basic_last_data", 64'(log_q[s+15].data), 64'h0000_0010);
    chk("basic_latency", 64'(rise_q[0] - acc_q[BL-1]), 64'd2);
    reg_read(12'd2, rd);
    chk("basic_status", 64'(rd), 64'h0001_0000);

    // Waitrequest stall mid-burst
    s = log_q.size();
    st0 = n_stall;
    model_frame(32'h100);
    fork
      send_pixels(32'h100, FW, 1'b1);
      begin
        wait_log(s + 5);
        m_waitrequest = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m_waitrequest = 1'b0;
      end
    join
    wait_done(2);
    chk("stall_cycles", 64'(n_stall - st0), 64'd3);
    chk("stall_beats", 64'(log_q.size() - s), 64'(FW));

    // Pre-sof pixels are discarded
    s = log_q.size();
    send_pixels(32'h200, 5, 1'b0);
    model_frame(32'h300);
    send_pixels(32'h300, FW, 1'b1);
    wait_done(3);
    chk("presof_first_data", 64'(log_q[s].data), 64'h0000_0300);
    chk("presof_first_addr", 64'(log_q[s].addr), 64'h400);

    // Backpressure from a stalled master
    m_waitrequest = 1'b1;
    s = log_q.size();
    a0 = n_acc;
    model_frame(32'h400);
    fork
      send_pixels(32'h400, FW, 1'b1);
      begin
        repeat (20) @(posedge clk);
        #1;
        chk("bp_accepted", 64'(n_acc - a0), 64'(FD));
        chk("bp_px_ready", 64'(px_ready), 64'd0);
        reg_read(12'd2, rd);
        chk("bp_status_bits", 64'(rd[2:0]), 64'b001);
        m_waitrequest = 1'b0;
      end
    join
    wait_done(4);
    chk("bp_beats", 64'(log_q.size() - s), 64'(FW));
    reg_read(12'd2, rd);
    chk("bp_overflow", 64'(rd[1]), 64'd0);

    // BASE rewritten mid-frame applies to the next frame only
    s = log_q.size();
    model_frame(32'h500);
    fork
      send_pixels(32'h500, FW, 1'b1);
      begin
        repeat (6) @(posedge clk);
        reg_write(12'd0, 32'h0000_2000);
      end
    join
    model_base_w = 30'h800;
    wait_done(5);
    chk("base_f1_last_addr", 64'(log_q[s+15].addr), 64'h40C);
    s = log_q.size();
    model_frame(32'h600);
    send_pixels(32'h600, FW, 1'b1);
    wait_done(6);
    chk("base_f2_first_addr", 64'(log_q[s].addr), 64'h800);
    chk("base_f2_last_addr", 64'(log_q[s+15].addr), 64'h80C);

    // Asynchronous reset between beats 2 and 3
    s = log_q.size();
    model_frame(32'h700);
    fork
      send_pixels(32'h700, FW, 1'b1);
      begin
        wait_log(s + 2);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_m_write", 64'(m_write), 64'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    chk("arst_beats", 64'(log_q.size() - s), 64'd2);
    reg_read(12'd2, rd);
    chk("arst_status", 64'(rd), 64'd0);
    model_base_w = '0;
    reg_write(12'd1, 32'h1);
    s = log_q.size();
    model_frame(32'h800);
    send_pixels(32'h800, FW, 1'b1);
    wait_done(7);
    chk("arst_first_addr", 64'(log_q[s].addr), 64'h0);
    chk("arst_first_data", 64'(log_q[s].data), 64'h0000_0800);
    reg_read(12'd2, rd);
    chk("arst_status_after", 64'(rd), 64'h0001_0000);

    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
